// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide,
// plus MTHI/MTLO writes. busy covers the whole operation; done pulses after the HI/LO commit.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multdiv,
    input  logic [5:0]       function_code,
    input  logic             hi_wren,
    input  logic             lo_wren,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for a start or an MTHI/MTLO write
    // RUN    | one multiply or divide step per cycle, count 0..ITER-1
    // FINISH | sign correction and HI/LO commit
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    state_t state, state_next;

    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div_zero;

    logic               start;
    logic               signed_op;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Function codes 24..27 share the upper bits; bit 1 selects divide, bit 0 unsigned.
    assign start     = (state == IDLE) && multdiv && (function_code[5:2] == 4'b0110);
    assign signed_op = ~function_code[0];
    assign a_mag     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign b_mag     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    assign busy = (state != IDLE);

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient bits}, shifted left each step.
    // div_rem stays below twice the divisor, so the MSB of div_diff is a clean borrow.
    assign div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_rem - {1'b0, operand};
    assign div_next = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_q ? -acc : acc;
    assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == LAST) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            count    <= '0;
            acc      <= '0;
            operand  <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        is_div   <= function_code[1];
                        neg_q    <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_r    <= signed_op && op_a[WIDTH-1];
                        div_zero <= (op_b == '0);
                        operand  <= function_code[1] ? b_mag : a_mag;
                        acc      <= {{WIDTH{1'b0}}, (function_code[1] ? a_mag : b_mag)};
                    end else if (!multdiv) begin
                        if (hi_wren) hi <= op_a;
                        if (lo_wren) lo <= op_a;
                    end
                end
                RUN: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                end
                FINISH: begin
                    count <= '0;
                    done  <= 1'b1;
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (!div_zero) begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model
// (native 64-bit multiply, divide and modulo) for HI/LO, busy window and done pulse.
module tb_muldiv_unit;

    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_DIV   = 6'd26;
    localparam logic [5:0] FN_DIVU  = 6'd27;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        multdiv = 1'b0;
    logic [5:0]  function_code = '0;
    logic        hi_wren = 1'b0;
    logic        lo_wren = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
        .clk(clk),
        .reset(reset),
        .multdiv(multdiv),
        .function_code(function_code),
        .hi_wren(hi_wren),
        .lo_wren(lo_wren),
        .op_a(op_a),
        .op_b(op_b),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: HI/LO after an operation, from plain integer arithmetic.
    task automatic model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (fn)
            FN_MULT: begin
                p = 64'(sa * sb);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            FN_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            FN_DIV: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    exp_lo = q[31:0];
                    exp_hi = r[31:0];
                end
            end
            FN_DIVU: begin
                if (b != 0) begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a start (with the decoder's wren bits also high) and checks acceptance.
    task automatic start_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        multdiv = 1'b1;
        function_code = fn;
        op_a = a;
        op_b = b;
        hi_wren = 1'b1;
        lo_wren = 1'b1;
        tick();
        multdiv = 1'b0;
        hi_wren = 1'b0;
        lo_wren = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        check("busy_after_start", {63'b0, busy}, 64'd1);
        check("done_low_after_start", {63'b0, done}, 64'd0);
        model(fn, a, b);
    endtask

    // n0 = busy sample points already stepped over since the start edge.
    task automatic wait_done(input int n0, input string tag);
        int n;
        n = n0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, {63'b0, done}, 64'd1);
        check({tag, "_hi"}, {32'b0, hi}, {32'b0, exp_hi});
        check({tag, "_lo"}, {32'b0, lo}, {32'b0, exp_lo});
    endtask

    function automatic logic [31:0] pick_value();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'h0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(1, 20));
            4:       v = -32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;

        tick();
        check("reset_hi", {32'b0, hi}, 64'd0);
        check("reset_lo", {32'b0, lo}, 64'd0);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        hi_wren = 1'b1;
        op_a = 32'h1234_5678;
        tick();
        hi_wren = 1'b0;
        exp_hi = 32'h1234_5678;
        check("mthi_hi", {32'b0, hi}, {32'b0, exp_hi});
        check("mthi_lo", {32'b0, lo}, 64'd0);
        check("mthi_busy", {63'b0, busy}, 64'd0);
        lo_wren = 1'b1;
        op_a = 32'h9ABC_DEF0;
        tick();
        lo_wren = 1'b0;
        exp_lo = 32'h9ABC_DEF0;
        check("mtlo_lo", {32'b0, lo}, {32'b0, exp_lo});
        check("mtlo_hi", {32'b0, hi}, {32'b0, exp_hi});
        check("mtlo_done", {63'b0, done}, 64'd0);

        multdiv = 1'b1;
        function_code = 6'd16;
        op_a = 32'd9;
        op_b = 32'd9;
        tick();
        multdiv = 1'b0;
        check("badfn_busy", {63'b0, busy}, 64'd0);
        check("badfn_hi", {32'b0, hi}, {32'b0, exp_hi});

        start_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, "multu_max");
        check("multu_max_hi_const", {32'b0, hi}, 64'hFFFF_FFFE);
        check("multu_max_lo_const", {32'b0, lo}, 64'h0000_0001);
        tick();
        check("done_one_cycle", {63'b0, done}, 64'd0);

        start_op(FN_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(0, "mult_neg");
        start_op(FN_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done(0, "mult_minmin");
        start_op(FN_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, "div_neg");
        start_op(FN_DIVU, 32'd100, 32'd7);
        wait_done(0, "divu_100_7");
        start_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, "div_overflow");
        check("div_overflow_lo_const", {32'b0, lo}, 64'h8000_0000);

        start_op(FN_DIVU, 32'd100, 32'd7);
        wait_done(0, "divu_setup");
        start_op(FN_DIVU, 32'd55, 32'd0);
        wait_done(0, "divu_zero");

        start_op(FN_MULTU, 32'd5, 32'd6);
        repeat (9) tick();
        multdiv = 1'b1;
        function_code = FN_DIVU;
        hi_wren = 1'b1;
        op_a = 32'hDEAD_BEEF;
        op_b = 32'd3;
        tick();
        multdiv = 1'b0;
        hi_wren = 1'b0;
        wait_done(10, "ignore_while_busy");

        start_op(FN_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (14) tick();
        reset = 1'b1;
        #1;
        check("midreset_hi", {32'b0, hi}, 64'd0);
        check("midreset_lo", {32'b0, lo}, 64'd0);
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_done", {63'b0, done}, 64'd0);
        tick();
        reset = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        tick();
        start_op(FN_MULTU, 32'd3, 32'd4);
        wait_done(0, "after_reset");

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                hi_wren = 1'($urandom_range(0, 1));
                lo_wren = 1'($urandom_range(0, 1));
                op_a = $urandom;
                if (hi_wren) exp_hi = op_a;
                if (lo_wren) exp_lo = op_a;
                tick();
                hi_wren = 1'b0;
                lo_wren = 1'b0;
                check($sformatf("rand%0d_mt_hi", i), {32'b0, hi}, {32'b0, exp_hi});
                check($sformatf("rand%0d_mt_lo", i), {32'b0, lo}, {32'b0, exp_lo});
            end
            fn = FN_MULT + 6'($urandom_range(0, 3));
            a = pick_value();
            b = pick_value();
            start_op(fn, a, b);
            wait_done(0, $sformatf("rand%0d_fn%0d", i, fn));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
